matmul_sequencer: RTL and testbench
===================================

Name: matmul_sequencer

Overview:
Controller that sequences one matrix multiply C = A x B over shared single-port-read A/B memories and a write port to C memory. Accepts a job descriptor (base addresses, dimensions N, M, P) through a valid/ready handshake and walks the i/j/k loops. It issues the A/B reads, multiply-accumulates the returned words, and writes each C element. It is the sequencing front end of the matrix_multiplication datapath.

Parameters:
ADDR_WIDTH, 12, width of all memory addresses and base addresses
DATA_WIDTH, 32, width of matrix elements, accumulator and C write data
DIM_WIDTH, 4, width of N, M, P (max dimension 2^DIM_WIDTH-1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
valid_in  in  1  job request valid
ready_out  out  1  sequencer can accept a job
matrix_a_addr  in  ADDR_WIDTH  base address of A (row-major, N x M)
matrix_b_addr  in  ADDR_WIDTH  base address of B (row-major, M x P)
matrix_c_addr  in  ADDR_WIDTH  base address of C (row-major, N x P)
N  in  DIM_WIDTH  rows of A and C
M  in  DIM_WIDTH  columns of A, rows of B
P  in  DIM_WIDTH  columns of B and C
a_rd_en  out  1  A read strobe
a_rd_addr  out  ADDR_WIDTH  A read address
a_rd_data  in  DATA_WIDTH  A read data, valid 1 cycle after a_rd_en
b_rd_en  out  1  B read strobe
b_rd_addr  out  ADDR_WIDTH  B read address
b_rd_data  in  DATA_WIDTH  B read data, valid 1 cycle after b_rd_en
c_wr_en  out  1  C write strobe
c_wr_addr  out  ADDR_WIDTH  C write address
result_out  out  DATA_WIDTH  C write data (accumulated element)
valid_out  out  1  one-cycle pulse: job finished
err_out  out  1  qualifies valid_out: job had a zero dimension

Behaviour:
- Reset (async, any state): state=IDLE; ready_out=1; all strobes, valid_out, err_out=0; addresses, result_out, accumulator, i/j/k counters=0. An in-flight job is dropped with no further reads or writes.
- Handshake: job accepted on a rising edge with valid_in&&ready_out. ready_out=1 only in IDLE. All descriptor inputs are captured at acceptance; later changes are ignored. valid_in outside IDLE is ignored (not queued).
- States: IDLE -> (accept, any dim==0) ZERO -> IDLE. IDLE -> (accept, dims nonzero) READ -> LAST -> WRITE -> READ (next element) or DONE -> IDLE.
- ZERO: one cycle. valid_out=1, err_out=1. No reads or writes.
- READ: M cycles, k=0..M-1. a_rd_en=b_rd_en=1, a_rd_addr=A+i*M+k, b_rd_addr=B+k*P+j. Accumulator clears when k=0 is issued. Each returned pair is accumulated in the cycle after its issue.
- LAST: one cycle. The final product is accumulated. No strobes.
- WRITE: one cycle. c_wr_en=1, c_wr_addr=C+i*P+j, result_out=accumulator. Then advance j; on j=P-1 wrap j to 0 and advance i. After element (N-1,P-1), go to DONE.
- DONE: one cycle. valid_out=1, err_out=0. Then IDLE with ready_out=1.
- Element order is row-major (i outer, j inner). Each element costs M+2 cycles. The last write occurs N*P*(M+2) cycles after acceptance; valid_out follows in the next cycle.
- Arithmetic: unsigned. Each product is the low DATA_WIDTH bits of a_rd_data*b_rd_data. The accumulator wraps modulo 2^DATA_WIDTH with no saturation or flag.
- Address arithmetic is modulo 2^ADDR_WIDTH; base+offset wraps silently.
- Strobes are zero in every state except those listed above. result_out holds its last written value between writes.

Test Plan:
- 2x2x2 job, A=[1 2;3 4] at 0x000, B=[5 6;7 8] at 0x010, C at 0x020 -> writes 19,22,43,50 to 0x020..0x023 in order; c_wr_en at cycles 4,8,12,16 after accept; valid_out at cycle 17, err_out=0.
- N=1,M=1,P=1, A[0]=7, B[0]=6 -> single write 42 at the C base, 3 cycles after accept; valid_out at cycle 4.
- M=0 (N=P=3) -> valid_out=err_out=1 the cycle after accept; no a_rd_en, b_rd_en or c_wr_en ever asserted; ready_out back to 1 next cycle.
- 4x4x4 random job with valid_in held high and inputs changed mid-job -> ready_out=0 throughout; results match a reference model using the captured descriptor; second job accepted only after valid_out.
- A base 0xFFE, M=4 -> a_rd_addr sequence 0xFFE,0xFFF,0x000,0x001. With both operands 0xFFFFFFFF (M=2), result_out=0x00000002.
- rst asserted during READ of element (1,0) of a 3x3x3 job -> outputs zero and ready_out=1 asynchronously; no subsequent c_wr_en; a new job runs correctly after release.

Source files
------------

// File: rtl/matmul_sequencer.sv
// Sequences one C = A x B job: issues paired A/B reads, accumulates products, writes each C element.
// Latency: M+2 cycles per C element; done pulse one cycle after the last write (N*P*(M+2)+1 after accept).
// Backpressure: ready_out is high only when idle; requests arriving while busy are ignored, not queued.
module matmul_sequencer #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int DIM_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    output logic                  ready_out,
    input  logic [ADDR_WIDTH-1:0] matrix_a_addr,
    input  logic [ADDR_WIDTH-1:0] matrix_b_addr,
    input  logic [ADDR_WIDTH-1:0] matrix_c_addr,
    input  logic [DIM_WIDTH-1:0]  N,
    input  logic [DIM_WIDTH-1:0]  M,
    input  logic [DIM_WIDTH-1:0]  P,
    output logic                  a_rd_en,
    output logic [ADDR_WIDTH-1:0] a_rd_addr,
    input  logic [DATA_WIDTH-1:0] a_rd_data,
    output logic                  b_rd_en,
    output logic [ADDR_WIDTH-1:0] b_rd_addr,
    input  logic [DATA_WIDTH-1:0] b_rd_data,
    output logic                  c_wr_en,
    output logic [ADDR_WIDTH-1:0] c_wr_addr,
    output logic [DATA_WIDTH-1:0] result_out,
    output logic                  valid_out,
    output logic                  err_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ZERO,
        S_READ,
        S_LAST,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [DIM_WIDTH-1:0]  DIM_ONE  = DIM_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    state_t state, state_nxt;

    // Captured descriptor and loop counters.
    logic [DIM_WIDTH-1:0]  n_q, m_q, p_q;
    logic [DIM_WIDTH-1:0]  i_q, j_q, k_q;

    // Running address pointers replace i*M / k*P multiplies:
    // a_row = A + i*M, b_col = B + j, b_ptr = B + k*P + j, c_ptr = C + i*P + j.
    logic [ADDR_WIDTH-1:0] a_row, b_base, b_col, b_ptr, c_ptr;

    logic [DATA_WIDTH-1:0] acc, res_q, prod;

    logic accept, dim_zero, k_last, j_last, i_last;
    logic [ADDR_WIDTH-1:0] k_ext, m_ext, p_ext;

    assign accept   = valid_in && (state == S_IDLE);
    assign dim_zero = (N == '0) || (M == '0) || (P == '0);
    assign k_last   = (k_q == m_q - DIM_ONE);
    assign j_last   = (j_q == p_q - DIM_ONE);
    assign i_last   = (i_q == n_q - DIM_ONE);
    assign k_ext    = ADDR_WIDTH'(k_q);
    assign m_ext    = ADDR_WIDTH'(m_q);
    assign p_ext    = ADDR_WIDTH'(p_q);
    // Low DATA_WIDTH bits of the product; the accumulator wraps silently.
    assign prod     = a_rd_data * b_rd_data;

    // State register; reset abandons any job in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state selection.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = dim_zero ? S_ZERO : S_READ;
            S_ZERO:  state_nxt = S_IDLE;
            S_READ:  if (k_last) state_nxt = S_LAST;
            S_LAST:  state_nxt = S_WRITE;
            S_WRITE: state_nxt = (i_last && j_last) ? S_DONE : S_READ;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Moore outputs; addresses are forced to zero whenever their strobe is low.
    always_comb begin
        ready_out  = 1'b0;
        a_rd_en    = 1'b0;
        b_rd_en    = 1'b0;
        a_rd_addr  = '0;
        b_rd_addr  = '0;
        c_wr_en    = 1'b0;
        c_wr_addr  = '0;
        result_out = res_q;
        valid_out  = 1'b0;
        err_out    = 1'b0;
        case (state)
            S_IDLE: ready_out = 1'b1;
            S_ZERO: begin
                valid_out = 1'b1;
                err_out   = 1'b1;
            end
            S_READ: begin
                a_rd_en   = 1'b1;
                b_rd_en   = 1'b1;
                a_rd_addr = a_row + k_ext;
                b_rd_addr = b_ptr;
            end
            S_WRITE: begin
                c_wr_en    = 1'b1;
                c_wr_addr  = c_ptr;
                result_out = acc;
            end
            S_DONE: valid_out = 1'b1;
            default: ;
        endcase
    end

    // Descriptor capture, loop counters, pointers and multiply-accumulate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_q    <= '0;
            m_q    <= '0;
            p_q    <= '0;
            i_q    <= '0;
            j_q    <= '0;
            k_q    <= '0;
            a_row  <= '0;
            b_base <= '0;
            b_col  <= '0;
            b_ptr  <= '0;
            c_ptr  <= '0;
            acc    <= '0;
            res_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        n_q    <= N;
                        m_q    <= M;
                        p_q    <= P;
                        i_q    <= '0;
                        j_q    <= '0;
                        k_q    <= '0;
                        a_row  <= matrix_a_addr;
                        b_base <= matrix_b_addr;
                        b_col  <= matrix_b_addr;
                        b_ptr  <= matrix_b_addr;
                        c_ptr  <= matrix_c_addr;
                    end
                end
                S_READ: begin
                    k_q   <= k_last ? '0 : k_q + DIM_ONE;
                    b_ptr <= b_ptr + p_ext;
                    // Data for issue k arrives during issue k+1; k=0 starts a fresh sum.
                    if (k_q == '0) acc <= '0;
                    else           acc <= acc + prod;
                end
                S_LAST: acc <= acc + prod;
                S_WRITE: begin
                    res_q <= acc;
                    c_ptr <= c_ptr + ADDR_ONE;
                    if (j_last) begin
                        j_q   <= '0;
                        i_q   <= i_q + DIM_ONE;
                        a_row <= a_row + m_ext;
                        b_col <= b_base;
                        b_ptr <= b_base;
                    end else begin
                        j_q   <= j_q + DIM_ONE;
                        b_col <= b_col + ADDR_ONE;
                        b_ptr <= b_col + ADDR_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: directed and random jobs against a loop-level reference model.
// Latency: checks every write/done pulse at its exact cycle offset from acceptance.
// Backpressure: checks ready_out stays low for the whole job and that a busy request is ignored.
module tb_matmul_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic        ready_out;
    logic [11:0] a_base_in, b_base_in, c_base_in;
    logic [3:0]  n_in, m_in, p_in;
    logic        a_rd_en, b_rd_en, c_wr_en;
    logic [11:0] a_rd_addr, b_rd_addr, c_wr_addr;
    logic [31:0] a_rd_data, b_rd_data, result_out;
    logic        valid_out, err_out;

    logic [31:0] a_mem [0:4095];
    logic [31:0] b_mem [0:4095];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Observations of the most recent job.
    int          got_adr[$];
    int          got_off[$];
    logic [31:0] got_dat[$];
    int          got_a[$];
    int          got_b[$];

    matmul_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .valid_in     (valid_in),
        .ready_out    (ready_out),
        .matrix_a_addr(a_base_in),
        .matrix_b_addr(b_base_in),
        .matrix_c_addr(c_base_in),
        .N            (n_in),
        .M            (m_in),
        .P            (p_in),
        .a_rd_en      (a_rd_en),
        .a_rd_addr    (a_rd_addr),
        .a_rd_data    (a_rd_data),
        .b_rd_en      (b_rd_en),
        .b_rd_addr    (b_rd_addr),
        .b_rd_data    (b_rd_data),
        .c_wr_en      (c_wr_en),
        .c_wr_addr    (c_wr_addr),
        .result_out   (result_out),
        .valid_out    (valid_out),
        .err_out      (err_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read memories: data valid the cycle after the strobe.
    always @(posedge clk) begin
        if (a_rd_en) a_rd_data <= a_mem[a_rd_addr];
        if (b_rd_en) b_rd_data <= b_mem[b_rd_addr];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic scramble_inputs();
        a_base_in = 12'($urandom);
        b_base_in = 12'($urandom);
        c_base_in = 12'($urandom);
        n_in      = 4'($urandom);
        m_in      = 4'($urandom);
        p_in      = 4'($urandom);
    endtask

    // Runs one job, recording everything the DUT does, and compares with the model.
    task automatic run_job(input string name, input logic [11:0] ab, input logic [11:0] bb,
                           input logic [11:0] cb, input int n, input int m, input int p,
                           input bit mutate);
        int          exp_adr[$];
        logic [31:0] exp_dat[$];
        int          exp_a[$];
        int          exp_b[$];
        bit          zero;
        bit          done;
        int          c0, off, vo_off, nready, nm, limit;
        logic        verr;

        zero = (n == 0) || (m == 0) || (p == 0);
        if (!zero) begin
            for (int i = 0; i < n; i++) begin
                for (int j = 0; j < p; j++) begin
                    logic [31:0] sum;
                    sum = 0;
                    for (int k = 0; k < m; k++) begin
                        int aa, bx;
                        aa = (ab + i * m + k) % 4096;
                        bx = (bb + k * p + j) % 4096;
                        exp_a.push_back(aa);
                        exp_b.push_back(bx);
                        sum = sum + a_mem[aa] * b_mem[bx];
                    end
                    exp_adr.push_back((cb + i * p + j) % 4096);
                    exp_dat.push_back(sum);
                end
            end
        end

        got_adr.delete(); got_off.delete(); got_dat.delete();
        got_a.delete(); got_b.delete();

        @(negedge clk);
        check({name, " ready_idle"}, ready_out, 1);
        c0 = cyc;
        valid_in  = 1'b1;
        a_base_in = ab;
        b_base_in = bb;
        c_base_in = cb;
        n_in = 4'(n);
        m_in = 4'(m);
        p_in = 4'(p);

        done = 0; nready = 0; vo_off = -1; verr = 1'bx;
        limit = n * p * (m + 2) + 30;
        for (int t = 0; t < limit && !done; t++) begin
            @(negedge clk);
            if (mutate) scramble_inputs();
            else        valid_in = 1'b0;
            off = cyc - c0;
            if (ready_out) nready++;
            if (a_rd_en) got_a.push_back(int'(a_rd_addr));
            if (b_rd_en) got_b.push_back(int'(b_rd_addr));
            if (c_wr_en) begin
                got_adr.push_back(int'(c_wr_addr));
                got_dat.push_back(result_out);
                got_off.push_back(off);
            end
            if (valid_out) begin
                vo_off = off;
                verr   = err_out;
                done   = 1;
            end
        end
        valid_in = 1'b0;

        check({name, " finished"}, done, 1);
        check({name, " done_cycle"}, vo_off, zero ? 1 : n * p * (m + 2) + 1);
        check({name, " err"}, verr, zero);
        check({name, " ready_busy"}, nready, 0);
        check({name, " wr_cnt"}, got_dat.size(), exp_dat.size());
        for (int e = 0; e < got_dat.size() && e < exp_dat.size(); e++) begin
            check($sformatf("%s wr%0d_addr", name, e), got_adr[e], exp_adr[e]);
            check($sformatf("%s wr%0d_data", name, e), got_dat[e], exp_dat[e]);
            check($sformatf("%s wr%0d_cycle", name, e), got_off[e], (e + 1) * (m + 2));
        end
        check({name, " a_rd_cnt"}, got_a.size(), exp_a.size());
        check({name, " b_rd_cnt"}, got_b.size(), exp_b.size());
        nm = 0;
        for (int x = 0; x < got_a.size() && x < exp_a.size(); x++)
            if (got_a[x] != exp_a[x]) nm++;
        for (int x = 0; x < got_b.size() && x < exp_b.size(); x++)
            if (got_b[x] != exp_b[x]) nm++;
        check({name, " rd_addr_errs"}, nm, 0);
        if (exp_dat.size() > 0)
            check({name, " result_hold"}, result_out, exp_dat[exp_dat.size() - 1]);
    endtask

    initial begin
        int          nw;
        logic [31:0] exp4 [4];

        rst = 1'b1;
        valid_in = 1'b0;
        a_base_in = '0; b_base_in = '0; c_base_in = '0;
        n_in = '0; m_in = '0; p_in = '0;
        for (int x = 0; x < 4096; x++) begin
            a_mem[x] = $urandom;
            b_mem[x] = $urandom;
        end

        #1;
        check("reset ready", ready_out, 1);
        check("reset strobes", {a_rd_en, b_rd_en, c_wr_en, valid_out, err_out}, 0);
        check("reset result", result_out, 0);
        check("reset addrs", {a_rd_addr, b_rd_addr, c_wr_addr}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // 2x2x2 directed job.
        a_mem[0] = 1; a_mem[1] = 2; a_mem[2] = 3; a_mem[3] = 4;
        b_mem[16] = 5; b_mem[17] = 6; b_mem[18] = 7; b_mem[19] = 8;
        run_job("mm2", 12'h000, 12'h010, 12'h020, 2, 2, 2, 0);
        exp4[0] = 19; exp4[1] = 22; exp4[2] = 43; exp4[3] = 50;
        nw = got_dat.size();
        for (int e = 0; e < 4; e++)
            check($sformatf("mm2 const%0d", e), (e < nw) ? got_dat[e] : 32'hDEAD_BEEF, exp4[e]);

        // 1x1x1 job.
        a_mem[12'h040] = 7; b_mem[12'h050] = 6;
        run_job("mm1", 12'h040, 12'h050, 12'h060, 1, 1, 1, 0);
        check("mm1 const", (got_dat.size() > 0) ? got_dat[0] : 32'hDEAD_BEEF, 42);

        // Zero dimension jobs.
        run_job("zeroM", 12'h100, 12'h200, 12'h300, 3, 0, 3, 0);
        run_job("zeroN", 12'h100, 12'h200, 12'h300, 0, 2, 2, 0);

        // A base wraps past the top of the address space.
        run_job("awrap", 12'hFFE, 12'h123, 12'h456, 1, 4, 1, 0);
        check("awrap a2", (got_a.size() > 2) ? got_a[2] : -1, 0);
        check("awrap a3", (got_a.size() > 3) ? got_a[3] : -1, 1);

        // Accumulator wrap with all-ones operands.
        a_mem[12'h300] = 32'hFFFF_FFFF; a_mem[12'h301] = 32'hFFFF_FFFF;
        b_mem[12'h400] = 32'hFFFF_FFFF; b_mem[12'h401] = 32'hFFFF_FFFF;
        run_job("ones", 12'h300, 12'h400, 12'h500, 1, 2, 1, 0);
        check("ones const", (got_dat.size() > 0) ? got_dat[0] : 32'hDEAD_BEEF, 2);

        // 4x4x4 with valid held and descriptor scrambled mid-job, then a back-to-back job.
        run_job("mut4", 12'($urandom), 12'($urandom), 12'($urandom), 4, 4, 4, 1);
        run_job("after_mut", 12'($urandom), 12'($urandom), 12'($urandom), 2, 3, 2, 0);

        // Small random jobs.
        for (int r = 0; r < 6; r++)
            run_job($sformatf("rnd%0d", r), 12'($urandom), 12'($urandom), 12'($urandom),
                    $urandom_range(4, 1), $urandom_range(5, 1), $urandom_range(4, 1), 0);

        // Reset during READ of element (1,0) of a 3x3x3 job.
        begin
            int c0, nstrobe;
            @(negedge clk);
            c0 = cyc;
            valid_in = 1'b1;
            a_base_in = 12'h080; b_base_in = 12'h0C0; c_base_in = 12'h0F0;
            n_in = 3; m_in = 3; p_in = 3;
            @(negedge clk);
            valid_in = 1'b0;
            for (int t = 0; t < 40 && (cyc - c0) < 17; t++) @(negedge clk);
            check("rstmid pre_en", a_rd_en, 1);
            check("rstmid pre_addr", a_rd_addr, 12'h084);
            rst = 1'b1;
            #1;
            check("rstmid ready", ready_out, 1);
            check("rstmid strobes", {a_rd_en, b_rd_en, c_wr_en, valid_out, err_out}, 0);
            check("rstmid result", result_out, 0);
            check("rstmid addrs", {a_rd_addr, b_rd_addr, c_wr_addr}, 0);
            repeat (2) @(negedge clk);
            rst = 1'b0;
            nstrobe = 0;
            for (int t = 0; t < 40; t++) begin
                @(negedge clk);
                if (c_wr_en || a_rd_en || b_rd_en || valid_out) nstrobe++;
            end
            check("rstmid quiet", nstrobe, 0);
        end
        run_job("post_rst", 12'($urandom), 12'($urandom), 12'($urandom), 3, 3, 3, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
